uart_echo_responder: RTL and testbench

//  Far-end UART peer for the switch/LED UART link. Receives 8N1 frames on RxD

---
 rtl/uart_echo_responder.sv | 367 ++++++++++++++++++++++++++++++++++++
 tb/tb_uart_echo_responder.sv | 334 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_echo_responder.sv
// uart_echo_responder
// Far-end UART peer: receives 8N1 frames on RxD with 16x oversampling, buffers
// accepted bytes in a small FIFO and echoes them back on TxD. Reports every
// accepted byte, framing errors and FIFO overruns to local logic.
//
// Optional feature macro: PARITY_EN
//   defined   -> 8E1 frames, even-parity bit after the data bits on RX and TX
//   undefined -> 8N1 only, no parity state or parity logic
//
// RX FSM
//   state        | meaning
//   RX_IDLE      | line idle, waiting for a synced 1->0 edge
//   RX_START     | 8 ticks into the start bit, then re-check it (glitch filter)
//   RX_DATA      | sample 8 data bits LSB first, one every 16 ticks
//   RX_PARITY    | (PARITY_EN) sample parity bit, remember a mismatch
//   RX_STOP      | sample stop bit; 1 accepts (or drops on parity error), 0 is a framing error
//   RX_WAIT_IDLE | after a bad stop bit, wait for the line to return high
//
// TX FSM
//   state        | meaning
//   TX_IDLE      | TxD high; pop FIFO and start a frame when enabled
//   TX_START     | start bit (TxD=0) for 16 ticks
//   TX_DATA      | 8 data bits LSB first, 16 ticks each
//   TX_PARITY    | (PARITY_EN) even-parity bit for 16 ticks
//   TX_STOP      | stop bit (TxD=1) for 16 ticks
module uart_echo_responder #(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 9600,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          RxD,
  input  logic                          tx_enable,
  output logic                          TxD,
  output logic [7:0]                    rx_byte,
  output logic                          rx_valid,
  output logic                          frame_err,
  output logic                          overrun,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);

  localparam int DIV   = CLK_FREQ / (BAUD * 16);
  localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [DIV_W-1:0] DIV_RELOAD = DIV_W'(DIV - 1);
  localparam logic [CNT_W-1:0] FIFO_FULL  = CNT_W'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
`ifdef PARITY_EN
    RX_PARITY,
`endif
    RX_STOP,
    RX_WAIT_IDLE
  } rx_state_t;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
`ifdef PARITY_EN
    TX_PARITY,
`endif
    TX_STOP
  } tx_state_t;

  logic             rxd_meta_q, rxd_meta_d;
  logic             rxd_sync_q, rxd_sync_d;
  logic             rxd_prev_q, rxd_prev_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic             tick;

  rx_state_t        rx_state_q, rx_state_d;
  logic [3:0]       rx_tcnt_q, rx_tcnt_d;
  logic [2:0]       rx_bcnt_q, rx_bcnt_d;
  logic [7:0]       rx_shift_q, rx_shift_d;
`ifdef PARITY_EN
  logic             rx_perr_q, rx_perr_d;
`endif
  logic [7:0]       rx_byte_q, rx_byte_d;
  logic             rx_valid_q, rx_valid_d;
  logic             frame_err_q, frame_err_d;
  logic             overrun_q, overrun_d;
  logic             accept;

  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             full, push, pop;

  tx_state_t        tx_state_q, tx_state_d;
  logic [3:0]       tx_tcnt_q, tx_tcnt_d;
  logic [2:0]       tx_bcnt_q, tx_bcnt_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             txd_q, txd_d;

  assign tick = (div_q == '0);

  // RxD synchronizer, edge history and free-running oversample divider
  always_comb begin
    rxd_meta_d = RxD;
    rxd_sync_d = rxd_meta_q;
    rxd_prev_d = rxd_sync_q;
    div_d      = tick ? DIV_RELOAD : div_q - DIV_W'(1);
  end

  // RX frame decoder; the byte is taken from the shift register in the stop-bit clk
  always_comb begin
    rx_state_d  = rx_state_q;
    rx_tcnt_d   = rx_tcnt_q;
    rx_bcnt_d   = rx_bcnt_q;
    rx_shift_d  = rx_shift_q;
`ifdef PARITY_EN
    rx_perr_d   = rx_perr_q;
`endif
    rx_byte_d   = rx_byte_q;
    rx_valid_d  = 1'b0;
    frame_err_d = frame_err_q;
    accept      = 1'b0;
    case (rx_state_q)
      RX_IDLE: begin
        if (rxd_prev_q && !rxd_sync_q) begin
          rx_state_d = RX_START;
          rx_tcnt_d  = 4'd0;
        end
      end
      RX_START: begin
        if (tick) begin
          if (rx_tcnt_q == 4'd7) begin
            rx_tcnt_d  = 4'd0;
            rx_bcnt_d  = 3'd0;
            rx_state_d = rxd_sync_q ? RX_IDLE : RX_DATA;
          end else begin
            rx_tcnt_d = rx_tcnt_q + 4'd1;
          end
        end
      end
      RX_DATA: begin
        if (tick) begin
          if (rx_tcnt_q == 4'd15) begin
            rx_tcnt_d  = 4'd0;
            rx_shift_d = {rxd_sync_q, rx_shift_q[7:1]};
            if (rx_bcnt_q == 3'd7) begin
`ifdef PARITY_EN
              rx_state_d = RX_PARITY;
`else
              rx_state_d = RX_STOP;
`endif
            end else begin
              rx_bcnt_d = rx_bcnt_q + 3'd1;
            end
          end else begin
            rx_tcnt_d = rx_tcnt_q + 4'd1;
          end
        end
      end
`ifdef PARITY_EN
      RX_PARITY: begin
        if (tick) begin
          if (rx_tcnt_q == 4'd15) begin
            rx_tcnt_d  = 4'd0;
            rx_perr_d  = rxd_sync_q ^ (^rx_shift_q);
            rx_state_d = RX_STOP;
          end else begin
            rx_tcnt_d = rx_tcnt_q + 4'd1;
          end
        end
      end
`endif
      RX_STOP: begin
        if (tick) begin
          if (rx_tcnt_q == 4'd15) begin
            rx_tcnt_d = 4'd0;
            if (!rxd_sync_q) begin
              frame_err_d = 1'b1;
              rx_state_d  = RX_WAIT_IDLE;
            end else begin
              rx_state_d = RX_IDLE;
`ifdef PARITY_EN
              if (rx_perr_q) begin
                frame_err_d = 1'b1;
              end else begin
                accept     = 1'b1;
                rx_byte_d  = rx_shift_q;
                rx_valid_d = 1'b1;
              end
`else
              accept     = 1'b1;
              rx_byte_d  = rx_shift_q;
              rx_valid_d = 1'b1;
`endif
            end
          end else begin
            rx_tcnt_d = rx_tcnt_q + 4'd1;
          end
        end
      end
      RX_WAIT_IDLE: begin
        if (rxd_sync_q) rx_state_d = RX_IDLE;
      end
      default: rx_state_d = RX_IDLE;
    endcase
  end

  // FIFO bookkeeping and TX frame generator; a pop frees a slot for a same-clk push
  always_comb begin
    pop        = (tx_state_q == TX_IDLE) && (count_q != '0) && tx_enable;
    full       = (count_q == FIFO_FULL);
    push       = accept && (!full || pop);
    overrun_d  = overrun_q | (accept & full & ~pop);
    wr_ptr_d   = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_W'(1);
      2'b01:   count_d = count_q - CNT_W'(1);
      default: count_d = count_q;
    endcase

    tx_state_d = tx_state_q;
    tx_tcnt_d  = tx_tcnt_q;
    tx_bcnt_d  = tx_bcnt_q;
    tx_data_d  = tx_data_q;
    txd_d      = txd_q;
    case (tx_state_q)
      TX_IDLE: begin
        txd_d = 1'b1;
        if (pop) begin
          tx_state_d = TX_START;
          tx_data_d  = mem[rd_ptr_q];
          tx_tcnt_d  = 4'd0;
          txd_d      = 1'b0;
        end
      end
      TX_START: begin
        if (tick) begin
          if (tx_tcnt_q == 4'd15) begin
            tx_tcnt_d  = 4'd0;
            tx_bcnt_d  = 3'd0;
            tx_state_d = TX_DATA;
            txd_d      = tx_data_q[0];
          end else begin
            tx_tcnt_d = tx_tcnt_q + 4'd1;
          end
        end
      end
      TX_DATA: begin
        if (tick) begin
          if (tx_tcnt_q == 4'd15) begin
            tx_tcnt_d = 4'd0;
            if (tx_bcnt_q == 3'd7) begin
`ifdef PARITY_EN
              tx_state_d = TX_PARITY;
              txd_d      = ^tx_data_q;
`else
              tx_state_d = TX_STOP;
              txd_d      = 1'b1;
`endif
            end else begin
              tx_bcnt_d = tx_bcnt_q + 3'd1;
              txd_d     = tx_data_q[tx_bcnt_d];
            end
          end else begin
            tx_tcnt_d = tx_tcnt_q + 4'd1;
          end
        end
      end
`ifdef PARITY_EN
      TX_PARITY: begin
        if (tick) begin
          if (tx_tcnt_q == 4'd15) begin
            tx_tcnt_d  = 4'd0;
            tx_state_d = TX_STOP;
            txd_d      = 1'b1;
          end else begin
            tx_tcnt_d = tx_tcnt_q + 4'd1;
          end
        end
      end
`endif
      TX_STOP: begin
        if (tick) begin
          if (tx_tcnt_q == 4'd15) begin
            tx_tcnt_d  = 4'd0;
            tx_state_d = TX_IDLE;
          end else begin
            tx_tcnt_d = tx_tcnt_q + 4'd1;
          end
        end
      end
      default: begin
        tx_state_d = TX_IDLE;
        txd_d      = 1'b1;
      end
    endcase
  end

  // FIFO storage; contents need no reset since the pointers define validity
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr_q] <= rx_shift_q;
  end

  // State registers; reset forces TxD high even in the middle of a frame
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rxd_meta_q  <= 1'b1;
      rxd_sync_q  <= 1'b1;
      rxd_prev_q  <= 1'b1;
      div_q       <= '0;
      rx_state_q  <= RX_IDLE;
      rx_tcnt_q   <= 4'd0;
      rx_bcnt_q   <= 3'd0;
      rx_shift_q  <= 8'd0;
`ifdef PARITY_EN
      rx_perr_q   <= 1'b0;
`endif
      rx_byte_q   <= 8'd0;
      rx_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      tx_state_q  <= TX_IDLE;
      tx_tcnt_q   <= 4'd0;
      tx_bcnt_q   <= 3'd0;
      tx_data_q   <= 8'd0;
      txd_q       <= 1'b1;
    end else begin
      rxd_meta_q  <= rxd_meta_d;
      rxd_sync_q  <= rxd_sync_d;
      rxd_prev_q  <= rxd_prev_d;
      div_q       <= div_d;
      rx_state_q  <= rx_state_d;
      rx_tcnt_q   <= rx_tcnt_d;
      rx_bcnt_q   <= rx_bcnt_d;
      rx_shift_q  <= rx_shift_d;
`ifdef PARITY_EN
      rx_perr_q   <= rx_perr_d;
`endif
      rx_byte_q   <= rx_byte_d;
      rx_valid_q  <= rx_valid_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      tx_state_q  <= tx_state_d;
      tx_tcnt_q   <= tx_tcnt_d;
      tx_bcnt_q   <= tx_bcnt_d;
      tx_data_q   <= tx_data_d;
      txd_q       <= txd_d;
    end
  end

  assign TxD        = txd_q;
  assign rx_byte    = rx_byte_q;
  assign rx_valid   = rx_valid_q;
  assign frame_err  = frame_err_q;
  assign overrun    = overrun_q;
  assign fifo_count = count_q;

endmodule

// File: tb/tb_uart_echo_responder.sv
// Directed bench for uart_echo_responder at 4 clk/tick, 64 clk/bit, 4-entry FIFO.
`timescale 1ns/1ps
module tb_uart_echo_responder;

  localparam int CLK_FREQ = 6_400_000;
  localparam int BAUD     = 100_000;
  localparam int DEPTH    = 4;
`ifdef PARITY_EN
  localparam int FRAME_CLK = 704;
`else
  localparam int FRAME_CLK = 640;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       RxD = 1'b1;
  logic       tx_enable = 1'b1;
  logic       TxD;
  logic [7:0] rx_byte;
  logic       rx_valid;
  logic       frame_err;
  logic       overrun;
  logic [2:0] fifo_count;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  int         rxv_cnt  = 0;
  int         rxv_cyc  = 0;
  logic [7:0] rxv_byte = 8'd0;

  logic [7:0] tx_q[$];
  int         tx_fall_q[$];
  logic       tx_stop_q[$];
`ifdef PARITY_EN
  logic       tx_par_q[$];
  logic       mon_par;
`endif
  logic [7:0] mon_b;
  logic       mon_stop;
  int         mon_t;

  uart_echo_responder #(
    .CLK_FREQ  (CLK_FREQ),
    .BAUD      (BAUD),
    .FIFO_DEPTH(DEPTH)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .RxD       (RxD),
    .tx_enable (tx_enable),
    .TxD       (TxD),
    .rx_byte   (rx_byte),
    .rx_valid  (rx_valid),
    .frame_err (frame_err),
    .overrun   (overrun),
    .fifo_count(fifo_count)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  // record every rx_valid pulse
  always @(negedge clk) begin
    if (rx_valid === 1'b1) begin
      rxv_cnt  = rxv_cnt + 1;
      rxv_cyc  = cyc;
      rxv_byte = rx_byte;
    end
  end

  // TxD decoder: mid-bit sampling relative to the detected falling edge
  initial begin
    mon_b = 8'd0;
    mon_stop = 1'b0;
    mon_t = 0;
`ifdef PARITY_EN
    mon_par = 1'b0;
`endif
    forever begin
      @(negedge clk);
      if (reset === 1'b1 && TxD === 1'b0) begin
        mon_t = cyc;
        repeat (96) @(negedge clk);
        mon_b[0] = TxD;
        for (int i = 1; i < 8; i++) begin
          repeat (64) @(negedge clk);
          mon_b[i] = TxD;
        end
`ifdef PARITY_EN
        repeat (64) @(negedge clk);
        mon_par = TxD;
        tx_par_q.push_back(mon_par);
`endif
        repeat (64) @(negedge clk);
        mon_stop = TxD;
        tx_q.push_back(mon_b);
        tx_fall_q.push_back(mon_t);
        tx_stop_q.push_back(mon_stop);
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic drive_bit(input logic v);
    RxD = v;
    repeat (64) @(negedge clk);
  endtask

  // leaves RxD at the stop-bit value
  task automatic send_frame(input logic [7:0] b, input logic stop_b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
`ifdef PARITY_EN
    drive_bit(^b);
`endif
    drive_bit(stop_b);
  endtask

`ifdef PARITY_EN
  task automatic send_frame_badpar(input logic [7:0] b);
    drive_bit(1'b0);
    for (int i = 0; i < 8; i++) drive_bit(b[i]);
    drive_bit(~(^b));
    drive_bit(1'b1);
  endtask
`endif

  task automatic clear_tx();
    tx_q.delete();
    tx_fall_q.delete();
    tx_stop_q.delete();
`ifdef PARITY_EN
    tx_par_q.delete();
`endif
  endtask

  task automatic wait_tx(input int n, input int budget);
    int i = 0;
    while (tx_q.size() < n && i < budget) begin
      @(negedge clk);
      i++;
    end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      RxD = ~RxD;
    end
    total++; if (TxD !== 1'b1) begin bad++; $display("FAIL reset_txd: got %b want 1", TxD); end
    total++; if (rx_valid !== 1'b0) begin bad++; $display("FAIL reset_rx_valid: got %b want 0", rx_valid); end
    total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL reset_overrun: got %b want 0", overrun); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL reset_fifo_count: got %0d want 0", fifo_count); end
    total++; if (rx_byte !== 8'h00) begin bad++; $display("FAIL reset_rx_byte: got %h want 00", rx_byte); end
    @(negedge clk);
    RxD = 1'b1;
    reset = 1'b1;
    repeat (20) @(negedge clk);
  endtask

  task automatic test_echo();
    int n0 = rxv_cnt;
    int lat;
    clear_tx();
    send_frame(8'hA5, 1'b1);
    wait_tx(1, 1500);
    total++; if (rxv_cnt - n0 !== 1) begin bad++; $display("FAIL echo_rx_pulses: got %0d want 1", rxv_cnt - n0); end
    total++; if (rxv_byte !== 8'hA5) begin bad++; $display("FAIL echo_rx_byte: got %h want a5", rxv_byte); end
    total++; if (tx_q.size() !== 1) begin bad++; $display("FAIL echo_tx_frames: got %0d want 1", tx_q.size()); end
    if (tx_q.size() >= 1) begin
      lat = tx_fall_q[0] - rxv_cyc;
      total++; if (tx_q[0] !== 8'hA5) begin bad++; $display("FAIL echo_tx_byte: got %h want a5", tx_q[0]); end
      total++; if (tx_stop_q[0] !== 1'b1) begin bad++; $display("FAIL echo_tx_stop: got %b want 1", tx_stop_q[0]); end
      total++; if (lat < 0 || lat > 2) begin bad++; $display("FAIL echo_latency: got %0d clk want 0..2", lat); end
`ifdef PARITY_EN
      total++; if (tx_par_q[0] !== 1'b0) begin bad++; $display("FAIL echo_tx_parity: got %b want 0", tx_par_q[0]); end
`endif
    end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL echo_fifo_count: got %0d want 0", fifo_count); end
  endtask

  task automatic test_glitch();
    int n0 = rxv_cnt;
    int lows = 0;
    clear_tx();
    RxD = 1'b0;
    repeat (16) @(negedge clk);
    RxD = 1'b1;
    repeat (200) begin
      @(negedge clk);
      if (TxD !== 1'b1) lows++;
    end
    total++; if (rxv_cnt !== n0) begin bad++; $display("FAIL glitch_no_rx: got %0d pulses want 0", rxv_cnt - n0); end
    total++; if (lows !== 0) begin bad++; $display("FAIL glitch_txd_idle: got %0d low clks want 0", lows); end
    send_frame(8'h5A, 1'b1);
    wait_tx(1, 1500);
    total++; if (rxv_cnt - n0 !== 1 || rxv_byte !== 8'h5A) begin bad++; $display("FAIL glitch_next_rx: got %0d pulses byte %h want 1 pulse byte 5a", rxv_cnt - n0, rxv_byte); end
    total++; if (tx_q.size() !== 1) begin bad++; $display("FAIL glitch_next_tx_frames: got %0d want 1", tx_q.size()); end
    if (tx_q.size() >= 1) begin
      total++; if (tx_q[0] !== 8'h5A) begin bad++; $display("FAIL glitch_next_tx_byte: got %h want 5a", tx_q[0]); end
    end
  endtask

  task automatic test_framing();
    int n0 = rxv_cnt;
    clear_tx();
    send_frame(8'h3C, 1'b0);
    repeat (200) @(negedge clk);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL framing_err_set: got %b want 1", frame_err); end
    total++; if (rxv_cnt !== n0) begin bad++; $display("FAIL framing_no_rx: got %0d pulses want 0", rxv_cnt - n0); end
    total++; if (tx_q.size() !== 0 || TxD !== 1'b1) begin bad++; $display("FAIL framing_no_echo: got %0d frames txd %b want 0 frames txd 1", tx_q.size(), TxD); end
    RxD = 1'b1;
    repeat (100) @(negedge clk);
    send_frame(8'h11, 1'b1);
    wait_tx(1, 1500);
    total++; if (rxv_cnt - n0 !== 1 || rxv_byte !== 8'h11) begin bad++; $display("FAIL framing_next_rx: got %0d pulses byte %h want 1 pulse byte 11", rxv_cnt - n0, rxv_byte); end
    total++; if (tx_q.size() !== 1) begin bad++; $display("FAIL framing_next_tx_frames: got %0d want 1", tx_q.size()); end
    if (tx_q.size() >= 1) begin
      total++; if (tx_q[0] !== 8'h11) begin bad++; $display("FAIL framing_next_tx_byte: got %h want 11", tx_q[0]); end
    end
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL framing_err_sticky: got %b want 1", frame_err); end
  endtask

  task automatic test_overrun();
    int n0 = rxv_cnt;
    int gap;
    logic [7:0] exp_b;
    clear_tx();
    tx_enable = 1'b0;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1);
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL overrun_count_full: got %0d want 4", fifo_count); end
    total++; if (overrun !== 1'b0) begin bad++; $display("FAIL overrun_not_yet: got %b want 0", overrun); end
    send_frame(8'h05, 1'b1);
    repeat (4) @(negedge clk);
    total++; if (overrun !== 1'b1) begin bad++; $display("FAIL overrun_set: got %b want 1", overrun); end
    total++; if (fifo_count !== 3'd4) begin bad++; $display("FAIL overrun_count_held: got %0d want 4", fifo_count); end
    total++; if (rx_byte !== 8'h05) begin bad++; $display("FAIL overrun_rx_byte: got %h want 05", rx_byte); end
    total++; if (rxv_cnt - n0 !== 5) begin bad++; $display("FAIL overrun_rx_pulses: got %0d want 5", rxv_cnt - n0); end
    total++; if (tx_q.size() !== 0 || TxD !== 1'b1) begin bad++; $display("FAIL overrun_tx_held: got %0d frames txd %b want 0 frames txd 1", tx_q.size(), TxD); end
    tx_enable = 1'b1;
    wait_tx(4, 3200);
    total++; if (tx_q.size() !== 4) begin bad++; $display("FAIL overrun_tx_frames: got %0d want 4", tx_q.size()); end
    if (tx_q.size() >= 4) begin
      for (int k = 0; k < 4; k++) begin
        exp_b = 8'(k + 1);
        total++; if (tx_q[k] !== exp_b) begin bad++; $display("FAIL overrun_tx_byte%0d: got %h want %h", k, tx_q[k], exp_b); end
      end
      for (int k = 1; k < 4; k++) begin
        gap = tx_fall_q[k] - tx_fall_q[k-1];
        total++; if (gap < FRAME_CLK - 3 || gap > FRAME_CLK + 1) begin bad++; $display("FAIL overrun_b2b_gap%0d: got %0d clk want %0d..%0d", k, gap, FRAME_CLK - 3, FRAME_CLK + 1); end
      end
    end
    repeat (800) @(negedge clk);
    total++; if (tx_q.size() !== 4) begin bad++; $display("FAIL overrun_no_extra_tx: got %0d frames want 4", tx_q.size()); end
    total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL overrun_drained: got %0d want 0", fifo_count); end
  endtask

  task automatic test_reset_mid_frame();
    int lows = 0;
    clear_tx();
    fork
      send_frame(8'hF0, 1'b1);
      begin
        int i = 0;
        while (TxD !== 1'b0 && i < 1500) begin
          @(negedge clk);
          i++;
        end
        total++;
        if (TxD !== 1'b0) begin
          bad++; $display("FAIL midreset_tx_start: got txd %b want 0 within 1500 clk", TxD);
        end else begin
          repeat (288) @(negedge clk);
          total++; if (TxD !== 1'b0) begin bad++; $display("FAIL midreset_bit3_before: got %b want 0", TxD); end
          #2 reset = 1'b0;
          #1;
          total++; if (TxD !== 1'b1) begin bad++; $display("FAIL midreset_txd_high: got %b want 1", TxD); end
          total++; if (fifo_count !== 3'd0) begin bad++; $display("FAIL midreset_fifo_count: got %0d want 0", fifo_count); end
          total++; if (overrun !== 1'b0 || frame_err !== 1'b0) begin bad++; $display("FAIL midreset_sticky_clear: got overrun %b frame_err %b want 0 0", overrun, frame_err); end
        end
      end
    join
    repeat (3) @(negedge clk);
    reset = 1'b1;
    repeat (1000) begin
      @(negedge clk);
      if (TxD !== 1'b1) lows++;
    end
    total++; if (lows !== 0) begin bad++; $display("FAIL midreset_no_resend: got %0d low clks want 0", lows); end
    clear_tx();
    send_frame(8'h33, 1'b1);
    wait_tx(1, 1500);
    total++; if (tx_q.size() !== 1) begin bad++; $display("FAIL midreset_new_tx_frames: got %0d want 1", tx_q.size()); end
    if (tx_q.size() >= 1) begin
      total++; if (tx_q[0] !== 8'h33) begin bad++; $display("FAIL midreset_new_tx_byte: got %h want 33", tx_q[0]); end
    end
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    int n0 = rxv_cnt;
    clear_tx();
    send_frame_badpar(8'h01);
    repeat (800) @(negedge clk);
    total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL parity_err_set: got %b want 1", frame_err); end
    total++; if (rxv_cnt !== n0) begin bad++; $display("FAIL parity_no_rx: got %0d pulses want 0", rxv_cnt - n0); end
    total++; if (tx_q.size() !== 0) begin bad++; $display("FAIL parity_no_echo: got %0d frames want 0", tx_q.size()); end
  endtask
`endif

  initial begin
    test_reset();
    test_echo();
    test_glitch();
    test_framing();
    test_overrun();
    test_reset_mid_frame();
`ifdef PARITY_EN
    test_parity();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
